pe_array_scheduler: RTL and testbench

- Sequences a linear systolic array of processing_element-style PEs through the anti-diagonal wavefront of one Pair-HMM read/haplotype job.
- Per step, asserts per-PE enable, waits for every enabled PE to report done, then issues a one-cycle advance to the whole array.
- Sits between the job front-end (read/haplotype loaders) and the PE array; emits the current diagonal index so feeders can present bases and priors.

---
 rtl/hmm_pkg.sv | 43 ++++
 rtl/pe_enable_decode.sv | 38 +++
 rtl/pe_array_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_pe_array_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hmm_pkg.sv
// ---------------------------------------------------------------------------
// hmm_pkg
// Shared definitions for the Pair-HMM datapath and its control.
//   - NUM_PE_DEF / LEN_W_DEF : default array size and length-field width
//   - sched_state_e          : wavefront scheduler states
//   - pe_calcs               : per-PE match/insert/delete partial results
//   - transition_probs       : per-read-base transition priors
//   - diag_len()             : number of anti-diagonals of an R x H job
// ---------------------------------------------------------------------------
package hmm_pkg;

  localparam int NUM_PE_DEF = 8;
  localparam int LEN_W_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_ADV   = 3'd3,
    ST_FIN   = 3'd4
  } sched_state_e;

  typedef struct packed {
    logic [15:0] m_val;
    logic [15:0] i_val;
    logic [15:0] d_val;
  } pe_calcs;

  typedef struct packed {
    logic [15:0] mm;
    logic [15:0] mi;
    logic [15:0] md;
    logic [15:0] ii;
    logic [15:0] dd;
  } transition_probs;

  // R+H-1, one bit wider than the length fields so R=H=2^LEN_W-1 cannot wrap.
  function automatic logic [LEN_W_DEF:0] diag_len(input logic [LEN_W_DEF-1:0] r,
                                                   input logic [LEN_W_DEF-1:0] h);
    return {1'b0, r} + {1'b0, h} - {{LEN_W_DEF{1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/pe_enable_decode.sv
// ---------------------------------------------------------------------------
// pe_enable_decode
// Combinational wavefront mask: PE i works on cell (i, k-i) of diagonal k.
//   diag_idx  in  LEN_W   current anti-diagonal k
//   read_len  in  LEN_W   read length R
//   hap_len   in  LEN_W   haplotype length H
//   mask      out NUM_PE  mask[i] = (i < R) && (i <= k) && (k - i < H)
// Also used by the feeders to pick bases and priors for the active PEs.
// ---------------------------------------------------------------------------
module pe_enable_decode #(
  parameter int NUM_PE = 8,
  parameter int LEN_W  = 8
) (
  input  logic [LEN_W-1:0]  diag_idx,
  input  logic [LEN_W-1:0]  read_len,
  input  logic [LEN_W-1:0]  hap_len,
  output logic [NUM_PE-1:0] mask
);

  logic [LEN_W:0] k_ext_s;
  logic [LEN_W:0] r_ext_s;
  logic [LEN_W:0] h_ext_s;

  assign k_ext_s = {1'b0, diag_idx};
  assign r_ext_s = {1'b0, read_len};
  assign h_ext_s = {1'b0, hap_len};

  // Per-PE cell validity; the i <= k term guards the k - i subtraction.
  always_comb begin
    mask = {NUM_PE{1'b0}};
    for (int i = 0; i < NUM_PE; i++) begin
      mask[i] = ((LEN_W+1)'(i) < r_ext_s) &&
                ((LEN_W+1)'(i) <= k_ext_s) &&
                ((k_ext_s - (LEN_W+1)'(i)) < h_ext_s);
    end
  end

endmodule

// File: rtl/pe_array_scheduler.sv
// ---------------------------------------------------------------------------
// pe_array_scheduler
// Walks a linear PE array through the anti-diagonals of one Pair-HMM job.
//   clk        in   clock
//   reset_n    in   asynchronous active-low reset
//   start      in   job request, accepted only while ready=1
//   read_len   in   R, sampled on accepted start
//   hap_len    in   H, sampled on accepted start
//   pe_done    in   per-PE done levels
//   ready      out  high in IDLE
//   pe_clear   out  one-cycle PE clear at job start
//   pe_enable  out  per-PE enable for the current diagonal
//   advance    out  one-cycle wavefront step
//   diag_idx   out  current diagonal k
//   job_done   out  one-cycle pulse after the last diagonal
//   job_err    out  one-cycle pulse on rejected start (or watchdog abort)
// Optional build macro PE_SCHED_WATCHDOG_EN adds a per-diagonal timeout of
// WDOG_CYCLES RUN cycles that aborts the job back to IDLE.
// Every output is a register or a decode of registers; pe_done only steers
// the next state, so there is no combinational pe_done -> advance path.
// ---------------------------------------------------------------------------
module pe_array_scheduler
  import hmm_pkg::*;
#(
  parameter int NUM_PE      = NUM_PE_DEF,
  parameter int LEN_W       = LEN_W_DEF,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  read_len,
  input  logic [LEN_W-1:0]  hap_len,
  input  logic [NUM_PE-1:0] pe_done,
  output logic              ready,
  output logic              pe_clear,
  output logic [NUM_PE-1:0] pe_enable,
  output logic              advance,
  output logic [LEN_W-1:0]  diag_idx,
  output logic              job_done,
  output logic              job_err
);

  sched_state_e      state_r;
  sched_state_e      state_nxt_s;
  logic [LEN_W-1:0]  read_len_r;
  logic [LEN_W-1:0]  hap_len_r;
  logic [LEN_W-1:0]  diag_idx_r;
  logic              job_err_r;
  logic [NUM_PE-1:0] mask_s;
  logic              en_gate_s;
  logic              all_done_s;
  logic              start_bad_s;
  logic              last_diag_s;
  logic              timeout_s;

  pe_enable_decode #(
    .NUM_PE (NUM_PE),
    .LEN_W  (LEN_W)
  ) u_decode (
    .diag_idx (diag_idx_r),
    .read_len (read_len_r),
    .hap_len  (hap_len_r),
    .mask     (mask_s)
  );

  assign pe_enable  = en_gate_s ? mask_s : {NUM_PE{1'b0}};
  // Disabled PEs count as done, so spikes on them are irrelevant.
  assign all_done_s = &(pe_done | ~pe_enable);

  assign start_bad_s = (read_len == {LEN_W{1'b0}}) ||
                       (hap_len == {LEN_W{1'b0}}) ||
                       ((LEN_W+1)'(read_len) > (LEN_W+1)'(NUM_PE));

  // Last diagonal when k+1 == R+H-1, evaluated one bit wide of LEN_W.
  assign last_diag_s = (({1'b0, diag_idx_r} + {{LEN_W{1'b0}}, 1'b1}) ==
                        (LEN_W+1)'(diag_len(LEN_W_DEF'(read_len_r), LEN_W_DEF'(hap_len_r))));

`ifdef PE_SCHED_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES) + 1;
  logic [WDOG_W-1:0] wdog_cnt_r;

  // RUN-cycle counter; zero whenever RUN is (re)entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt_r <= {WDOG_W{1'b0}};
    end else if (state_r == ST_RUN) begin
      wdog_cnt_r <= wdog_cnt_r + {{(WDOG_W-1){1'b0}}, 1'b1};
    end else begin
      wdog_cnt_r <= {WDOG_W{1'b0}};
    end
  end

  assign timeout_s = (state_r == ST_RUN) && !all_done_s &&
                     (wdog_cnt_r == WDOG_W'(WDOG_CYCLES - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && !start_bad_s) begin
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: state_nxt_s = ST_RUN;
      ST_RUN: begin
        if (all_done_s) begin
          state_nxt_s = ST_ADV;
        end else if (timeout_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_ADV: begin
        if (last_diag_s) begin
          state_nxt_s = ST_FIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FIN:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode from the state register.
  always_comb begin
    ready     = 1'b0;
    pe_clear  = 1'b0;
    advance   = 1'b0;
    job_done  = 1'b0;
    en_gate_s = 1'b0;
    case (state_r)
      ST_IDLE:  ready = 1'b1;
      ST_CLEAR: pe_clear = 1'b1;
      ST_RUN:   en_gate_s = 1'b1;
      ST_ADV: begin
        advance   = 1'b1;
        en_gate_s = 1'b1;
      end
      ST_FIN:   job_done = 1'b1;
      default:  ready = 1'b0;
    endcase
  end

  // Job parameters, diagonal index and error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_len_r <= {LEN_W{1'b0}};
      hap_len_r  <= {LEN_W{1'b0}};
      diag_idx_r <= {LEN_W{1'b0}};
      job_err_r  <= 1'b0;
    end else begin
      job_err_r <= ((state_r == ST_IDLE) && start && start_bad_s) || timeout_s;
      case (state_r)
        ST_IDLE: begin
          if (start && !start_bad_s) begin
            read_len_r <= read_len;
            hap_len_r  <= hap_len;
            diag_idx_r <= {LEN_W{1'b0}};
          end
        end
        ST_ADV: begin
          if (!last_diag_s) begin
            diag_idx_r <= diag_idx_r + {{(LEN_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          diag_idx_r <= diag_idx_r;
        end
      endcase
    end
  end

  assign diag_idx = diag_idx_r;
  assign job_err  = job_err_r;

endmodule

// File: tb/tb_pe_array_scheduler.sv
module tb_pe_array_scheduler;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] read_len;
  logic [7:0] hap_len;
  logic [7:0] pe_done;
  logic       ready;
  logic       pe_clear;
  logic [7:0] pe_enable;
  logic       advance;
  logic [7:0] diag_idx;
  logic       job_done;
  logic       job_err;

  pe_array_scheduler #(.NUM_PE(8), .LEN_W(8), .WDOG_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .read_len(read_len),
    .hap_len(hap_len), .pe_done(pe_done), .ready(ready), .pe_clear(pe_clear),
    .pe_enable(pe_enable), .advance(advance), .diag_idx(diag_idx),
    .job_done(job_done), .job_err(job_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // PE model: done for enabled PEs 5 cycles after each advance or clear.
  int   pe_cnt;
  logic [7:0] hold_mask;
  logic [7:0] force_mask;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) pe_cnt <= 0;
    else if (advance || pe_clear) pe_cnt <= 0;
    else if (pe_cnt < 1000) pe_cnt <= pe_cnt + 1;
  end
  assign pe_done = ((pe_cnt >= 5) ? (pe_enable & ~hold_mask) : 8'h00) | force_mask;

  typedef struct packed { logic [7:0] k; logic [7:0] mask; } exp_t;
  exp_t exp_q[$];

  int n_adv, n_done, n_clear, n_err;
  int last_adv_cyc, done_cyc, err_cyc, first_run_cyc, first_alld_cyc;
  logic [7:0] adv_mask [0:15];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] model_mask(input int k, input int r, input int h);
    logic [7:0] m;
    m = 8'h00;
    for (int i = 0; i < 8; i++) m[i] = (i < r) && (i <= k) && ((k - i) < h);
    return m;
  endfunction

  task automatic reset_counts();
    n_adv = 0; n_done = 0; n_clear = 0; n_err = 0;
    last_adv_cyc = -1; done_cyc = -1; err_cyc = -1;
    first_run_cyc = -1; first_alld_cyc = -1;
  endtask

  // Monitor / scoreboard consumer, sampling on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (advance) begin
          n_adv++;
          last_adv_cyc = cyc;
          if (diag_idx < 8'd16) adv_mask[diag_idx] = pe_enable;
          if (exp_q.size() == 0) begin
            check("adv_unexpected", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("adv_diag_idx", diag_idx, e.k);
            check("adv_pe_enable", pe_enable, e.mask);
          end
        end
        if (job_done) begin n_done++; done_cyc = cyc; end
        if (pe_clear) n_clear++;
        if (job_err) begin n_err++; err_cyc = cyc; end
        if ((pe_enable != 8'h00) && !advance) begin
          if (first_run_cyc < 0) first_run_cyc = cyc;
          if ((&(pe_done | ~pe_enable)) && first_alld_cyc < 0) first_alld_cyc = cyc;
        end
      end
    end
  end

  // Drive one start cycle; returns at the falling edge after the accepting edge.
  task automatic start_job(input int r, input int h, input bit push);
    if (push) begin
      for (int k = 0; k <= r + h - 2; k++) exp_q.push_back({8'(k), model_mask(k, r, h)});
    end
    start = 1'b1; read_len = 8'(r); hap_len = 8'(h);
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (n_done > 0) begin seen = 1'b1; break; end
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin @(negedge clk); #1; end
  endtask

  initial begin
    bit hit;
    reset_n = 1'b0; start = 1'b0; read_len = 8'd0; hap_len = 8'd0;
    hold_mask = 8'h00; force_mask = 8'h00;
    reset_counts();
    tick(2);
    check("rst_ready", ready, 1'b1);
    check("rst_pe_clear", pe_clear, 1'b0);
    check("rst_pe_enable", pe_enable, 8'h00);
    check("rst_advance", advance, 1'b0);
    check("rst_diag_idx", diag_idx, 8'h00);
    check("rst_job_done", job_done, 1'b0);
    check("rst_job_err", job_err, 1'b0);
    reset_n = 1'b1;
    tick(2);

    // R=3, H=4: six diagonals.
    reset_counts();
    start_job(3, 4, 1'b1);
    check("r3h4_pe_clear", pe_clear, 1'b1);
    check("r3h4_ready_low", ready, 1'b0);
    tick(1);
    check("r3h4_run_k0_mask", pe_enable, 8'h01);
    wait_done("r3h4_timeout", 300);
    check("r3h4_n_adv", n_adv, 32'd6);
    check("r3h4_mask_k0", adv_mask[0], 8'h01);
    check("r3h4_mask_k2", adv_mask[2], 8'h07);
    check("r3h4_mask_k4", adv_mask[4], 8'h06);
    check("r3h4_mask_k5", adv_mask[5], 8'h04);
    check("r3h4_done_lat", done_cyc - last_adv_cyc, 32'd1);
    tick(3);
    check("r3h4_n_done", n_done, 32'd1);
    check("r3h4_q_empty", exp_q.size(), 32'd0);
    check("r3h4_ready", ready, 1'b1);

    // R=1, H=1: single diagonal.
    reset_counts();
    start_job(1, 1, 1'b1);
    wait_done("r1h1_timeout", 100);
    check("r1h1_n_clear", n_clear, 32'd1);
    check("r1h1_n_adv", n_adv, 32'd1);
    check("r1h1_done_lat", done_cyc - first_alld_cyc, 32'd2);
    tick(2);

    // Rejected starts.
    reset_counts();
    start_job(9, 4, 1'b0);
    check("r9_job_err", job_err, 1'b1);
    check("r9_ready", ready, 1'b1);
    check("r9_pe_clear", pe_clear, 1'b0);
    tick(1);
    check("r9_err_pulse", job_err, 1'b0);
    start_job(2, 0, 1'b0);
    check("h0_job_err", job_err, 1'b1);
    check("h0_ready", ready, 1'b1);
    tick(3);
    check("rej_n_clear", n_clear, 32'd0);
    check("rej_n_err", n_err, 32'd2);

    // R=2, H=2 with a stuck-high done on disabled PE 7 and PE 1 withheld.
    reset_counts();
    force_mask = 8'h80; hold_mask = 8'h02;
    start_job(2, 2, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (diag_idx == 8'd1 && !advance) begin hit = 1'b1; break; end
    end
    check("hold_reach_k1", 32'(hit), 32'd1);
    tick(20);
    check("hold_no_adv", n_adv, 32'd1);
    check("hold_still_k1", diag_idx, 8'd1);
    hold_mask = 8'h00;
    wait_done("hold_timeout", 100);
    check("hold_n_adv", n_adv, 32'd3);
    force_mask = 8'h00;
    tick(2);

    // Reset in RUN at k=2 of an R=4, H=4 job.
    reset_counts();
    start_job(4, 4, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (diag_idx == 8'd2 && !advance && pe_enable != 8'h00) begin hit = 1'b1; break; end
    end
    check("mid_reach_k2", 32'(hit), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_ready", ready, 1'b1);
    check("mid_diag_idx", diag_idx, 8'd0);
    check("mid_pe_enable", pe_enable, 8'h00);
    check("mid_advance", advance, 1'b0);
    tick(1);
    reset_n = 1'b1;
    exp_q.delete();
    tick(3);
    check("mid_no_done", n_done, 32'd0);
    reset_counts();
    start_job(2, 3, 1'b1);
    check("mid_restart_clear", pe_clear, 1'b1);
    wait_done("mid_restart_timeout", 200);
    check("mid_restart_n_adv", n_adv, 32'd4);
    check("mid_restart_mask_k0", adv_mask[0], 8'h01);
    tick(2);

`ifdef PE_SCHED_WATCHDOG_EN
    // Watchdog: no PE ever reports done.
    reset_counts();
    hold_mask = 8'hFF;
    start_job(2, 2, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (n_err > 0) begin hit = 1'b1; break; end
    end
    check("wdog_seen", 32'(hit), 32'd1);
    check("wdog_lat", err_cyc - first_run_cyc, 32'd16);
    check("wdog_ready", ready, 1'b1);
    tick(3);
    check("wdog_n_adv", n_adv, 32'd0);
    check("wdog_n_done", n_done, 32'd0);
    hold_mask = 8'h00;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
